// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, helper and stage control word for the pipelined CLA
package cla_pkg;

  localparam int MAX_GROUP = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined CLA add/sub, one lookahead group per stage
// Optional ovf/zero flags are built when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int STAGES = WIDTH / GROUP;
  localparam int OPW    = (STAGES > 1) ? WIDTH - GROUP : 1;

  if (GROUP < 1 || GROUP > MAX_GROUP || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $fatal(1, "cla_pipe_addsub: WIDTH must be a multiple of GROUP, GROUP in 1..%0d", MAX_GROUP);
  end

  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  // Operand groups not yet consumed, shifted down so the next group sits at the bottom
  logic [OPW-1:0]   opa_q [STAGES];
  logic [OPW-1:0]   opb_q [STAGES];
`ifdef CLA_PIPE_FLAGS_EN
  logic             zero_q [STAGES];
  logic             ovf_q;
`endif

  logic             advance;
  logic [WIDTH-1:0] bx;

  assign advance  = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready = advance;
  assign bx       = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GROUP-1:0] ga, gb, gs;
    logic             gcin, gvld, gco, gcm;
    logic [WIDTH-1:0] sum_in, sum_nxt;
    logic [OPW-1:0]   opa_in, opb_in;

    if (k == 0) begin : g_first
      assign ga     = a[GROUP-1:0];
      assign gb     = bx[GROUP-1:0];
      assign gcin   = sub;
      assign gvld   = in_valid;
      assign sum_in = '0;
      if (STAGES > 1) begin : g_skew
        assign opa_in = a[WIDTH-1:GROUP];
        assign opb_in = bx[WIDTH-1:GROUP];
      end else begin : g_noskew
        assign opa_in = '0;
        assign opb_in = '0;
      end
    end else begin : g_next
      assign ga     = opa_q[k-1][GROUP-1:0];
      assign gb     = opb_q[k-1][GROUP-1:0];
      assign gcin   = ctl_q[k-1].carry;
      assign gvld   = ctl_q[k-1].valid;
      assign sum_in = sum_q[k-1];
      assign opa_in = opa_q[k-1] >> GROUP;
      assign opb_in = opb_q[k-1] >> GROUP;
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .a    (ga),
      .b    (gb),
      .cin  (gcin),
      .s    (gs),
      .cout (gco),
      .cmsb (gcm)
    );

    // Bits above this group are still zero in sum_in, so OR places the new group
    assign sum_nxt = sum_in | (WIDTH'(gs) << (k * GROUP));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end else if (advance) begin
        ctl_q[k].valid <= gvld;
        ctl_q[k].carry <= gco;
        sum_q[k]       <= sum_nxt;
        opa_q[k]       <= opa_in;
        opb_q[k]       <= opb_in;
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic zero_in;
    if (k == 0) begin : g_zero_first
      assign zero_in = 1'b1;
    end else begin : g_zero_next
      assign zero_in = zero_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) zero_q[k] <= 1'b0;
      else if (advance) zero_q[k] <= zero_in & ~|gs;
    end

    if (k == STAGES - 1) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (advance) ovf_q <= gcm ^ gco;
      end
    end
`endif
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign sum       = sum_q[STAGES-1];
  assign cout      = ctl_q[STAGES-1].carry;
`ifdef CLA_PIPE_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q[STAGES-1];
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - self-checking bench for cla_pipe_addsub (16/4 and 8/8 builds)
module tb_cla_pipe_addsub;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int ST = W / G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, sum;
  logic          r8_n, v8, rdy8, s8, ov8, ordy8, c8;
  logic [7:0]    a8, b8, sum8;
`ifdef CLA_PIPE_FLAGS_EN
  logic          ovf, zero, ovf8, zero8;
`endif

  cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_PIPE_FLAGS_EN
    , .ovf(ovf), .zero(zero)
`endif
  );

  cla_pipe_addsub #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk(clk), .rst_n(r8_n), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .sub(s8), .out_valid(ov8), .out_ready(ordy8),
    .sum(sum8), .cout(c8)
`ifdef CLA_PIPE_FLAGS_EN
    , .ovf(ovf8), .zero(zero8)
`endif
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t        q[$];
  int          qt[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          nres = 0;
  bit          got, chk_lat;
  logic [15:0] last_sum, snap;
  logic        last_cout, last_ovf, last_zero;
  int          last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic s);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = ia[w-1] ? ua - (1 << w) : ua;
    sb = ib[w-1] ? ub - (1 << w) : ub;
    r  = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    e.sum  = 16'(r & ((1 << w) - 1));
    e.cout = s ? (ua >= ub) : (r >= (1 << w));
    e.ovf  = (sr < -(1 << (w - 1))) || (sr >= (1 << (w - 1)));
    e.zero = ((r & ((1 << w) - 1)) == 0);
    return e;
  endfunction

  // One cycle on the 16-bit DUT: drive, observe output transfer, record input transfer
  task automatic op(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                    input logic is, input logic ord);
    exp_t e;
    int   t;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; sub = is; out_ready = ord;
    #1;
    got = 1'b0;
    if (out_valid && out_ready) begin
      chk("unexpected_out", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        t = qt.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
`ifdef CLA_PIPE_FLAGS_EN
        chk("ovf", ovf, e.ovf);
        chk("zero", zero, e.zero);
        last_ovf = ovf; last_zero = zero;
`endif
        last_sum = sum; last_cout = cout; last_lat = cyc - t;
        got = 1'b1;
        nres++;
        if (chk_lat) chk("latency", last_lat, ST);
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(W, ia, ib, is));
      qt.push_back(cyc);
    end
  endtask

  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                         input logic [15:0] xs, input logic xc);
    op(1'b1, ia, ib, is, 1'b1);
    for (int i = 0; i < 10 && !got; i++) op(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("result_timeout", got, 1);
    chk("dir_sum", last_sum, xs);
    chk("dir_cout", last_cout, xc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e8;
    int   n0;
    logic [7:0] x8, y8;
    logic [15:0] pa, pb;
    logic ps;

    rst_n = 1'b0; r8_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; ordy8 = 1'b1;
    chk_lat = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst8_out_valid", ov8, 0);
    @(negedge clk);
    rst_n = 1'b1; r8_n = 1'b1;

    run_one(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    chk("t1_latency", last_lat, ST);
    run_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef CLA_PIPE_FLAGS_EN
    chk("t2_zero", last_zero, 1);
    chk("t2_ovf", last_ovf, 0);
`endif
    run_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef CLA_PIPE_FLAGS_EN
    chk("t3_ovf", last_ovf, 1);
`endif
    run_one(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0);

    n0 = nres;
    for (int i = 0; i < 8; i++)
      op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < ST + 2; i++) op(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("t4_count", nres - n0, 8);
    chk("t4_drained", q.size(), 0);

    chk_lat = 1'b0;
    n0 = nres;
    for (int i = 0; i < ST; i++)
      op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    pa = 16'($urandom); pb = 16'($urandom); ps = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      op(1'b1, pa, pb, ps, 1'b0);
      if (i == 0) snap = sum;
      chk("t5_in_ready", in_ready, 0);
      chk("t5_out_valid", out_valid, 1);
      chk("t5_stable", sum, snap);
    end
    for (int i = 0; i < ST + 6; i++) op(i == 0, pa, pb, ps, 1'b1);
    chk("t5_count", nres - n0, ST + 1);
    chk("t5_drained", q.size(), 0);

    for (int i = 0; i < 3; i++)
      op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("t6_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_sum", sum, 0);
    chk("t6_async_cout", cout, 0);
    q.delete(); qt.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ST + 3; i++) begin
      op(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("t6_stale", out_valid, 0);
    end
    chk_lat = 1'b1;
    run_one(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 6; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom);
      @(negedge clk);
      a8 = x8; b8 = y8; s8 = 1'(i); v8 = 1'b1; ordy8 = 1'b1;
      e8 = model(8, {8'h0, x8}, {8'h0, y8}, s8);
      @(negedge clk);
      v8 = 1'b0;
      #1;
      chk("w8_valid", ov8, 1);
      chk("w8_sum", sum8, e8.sum[7:0]);
      chk("w8_cout", c8, e8.cout);
`ifdef CLA_PIPE_FLAGS_EN
      chk("w8_ovf", ovf8, e8.ovf);
      chk("w8_zero", zero8, e8.zero);
`endif
    end
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; s8 = 1'b0; v8 = 1'b1; ordy8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    #1;
    chk("w8_held_valid", ov8, 1);
    chk("w8_held_sum", sum8, 8'h8D);
    #2 r8_n = 1'b0;
    #1;
    chk("w8_async_valid", ov8, 0);
    chk("w8_async_sum", sum8, 0);
    @(negedge clk);
    r8_n = 1'b1; ordy8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("w8_stale", ov8, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
